// File: rtl/moore_seq_detector_pkg.sv
// Shared definitions for the Moore serial pattern detector: default pattern and
// the constant function that builds the prefix/suffix fallback transition table.
package moore_seq_detector_pkg;

  localparam int          MAX_PAT_LEN = 16;
  localparam int          DEF_PAT_LEN = 4;
  localparam logic [15:0] DEF_PATTERN = 16'b1001;

  // Next matched-prefix length after appending bit b to the first k pattern bits.
  // Pattern bit 0 (first received) lives at pat[len-1].
  function automatic int kmp_next(input logic [15:0] pat, input int len,
                                  input int k, input bit b);
    bit cand [0:MAX_PAT_LEN];
    int res;
    bit found;
    bit ok;
    res   = 0;
    found = 1'b0;
    for (int m = 0; m <= MAX_PAT_LEN; m++) begin
      if (m < k)
        cand[m] = pat[4'(len - 1 - m)];
      else if (m == k)
        cand[m] = b;
      else
        cand[m] = 1'b0;
    end
    for (int j = MAX_PAT_LEN; j >= 1; j--) begin
      if (!found && (j <= k + 1) && (j <= len)) begin
        ok = 1'b1;
        for (int i = 0; i < MAX_PAT_LEN; i++) begin
          if (i < j) begin
            if (cand[k + 1 - j + i] != pat[4'(len - 1 - i)])
              ok = 1'b0;
          end
        end
        if (ok) begin
          found = 1'b1;
          res   = j;
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/moore_seq_detector_if.sv
// Bit-stream and status bundle of the pattern detector.
// MOORE_DET_SAT_FLAG_EN adds the sticky counter-saturation flag cnt_sat.
interface moore_seq_detector_if #(
  parameter int PAT_LEN = 4,
  parameter int CNT_W   = 8
);
  localparam int SW = $clog2(PAT_LEN + 1);

  logic             din_vld;
  logic             din;
  logic             clr;
  logic             overlap_en;
  logic             qout;
  logic [CNT_W-1:0] match_cnt;
  logic [SW-1:0]    state_o;
`ifdef MOORE_DET_SAT_FLAG_EN
  logic             cnt_sat;

  modport master (output din_vld, din, clr, overlap_en,
                  input  qout, match_cnt, state_o, cnt_sat);
  modport slave  (input  din_vld, din, clr, overlap_en,
                  output qout, match_cnt, state_o, cnt_sat);
`else
  modport master (output din_vld, din, clr, overlap_en,
                  input  qout, match_cnt, state_o);
  modport slave  (input  din_vld, din, clr, overlap_en,
                  output qout, match_cnt, state_o);
`endif

endinterface

// File: rtl/moore_seq_detector_cnt.sv
// Saturating match counter with synchronous clear.
// MOORE_DET_SAT_FLAG_EN adds a sticky flag set once the count reaches all-ones.
module moore_det_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  input  logic             i_clr,
`ifdef MOORE_DET_SAT_FLAG_EN
  output logic             o_sat,
`endif
  output logic [CNT_W-1:0] o_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (i_inc && (r_cnt != CNT_MAX))
      w_cnt_nxt = r_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_cnt <= '0;
    else if (i_clr)
      r_cnt <= '0;
    else
      r_cnt <= w_cnt_nxt;
  end

  assign o_cnt = r_cnt;

`ifdef MOORE_DET_SAT_FLAG_EN
  logic r_sat;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_sat <= 1'b0;
    else if (i_clr)
      r_sat <= 1'b0;
    else
      r_sat <= r_sat | (w_cnt_nxt == CNT_MAX);
  end

  assign o_sat = r_sat;
`endif

endmodule

// File: rtl/moore_seq_detector.sv
// Moore serial pattern detector with overlap mode and saturating match counter.
// Optional build macro: MOORE_DET_SAT_FLAG_EN (exposes cnt_sat on the interface).
//
// state   | meaning
// 0       | no pattern bits matched
// k       | first k pattern bits matched (0 < k < PAT_LEN)
// PAT_LEN | MATCH: whole pattern seen, qout high
module moore_seq_detector
  import moore_seq_detector_pkg::*;
#(
  parameter int                 PAT_LEN = DEF_PAT_LEN,
  parameter logic [PAT_LEN-1:0] PATTERN = DEF_PATTERN[DEF_PAT_LEN-1:0],
  parameter int                 CNT_W   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  moore_seq_detector_if.slave   bus
);

  localparam int              SW       = $clog2(PAT_LEN + 1);
  localparam int              N_ST     = 2 ** SW;
  localparam logic [15:0]     PAT16    = 16'(PATTERN);
  localparam logic [SW-1:0]   ST_MATCH = SW'(PAT_LEN);

  // Transition table resolved at elaboration; unreachable codes recover to 0.
  logic [SW-1:0] w_nxt_tab [N_ST][2];

  for (genvar k = 0; k < N_ST; k++) begin : g_st
    for (genvar b = 0; b < 2; b++) begin : g_bit
      if (k <= PAT_LEN) begin : g_valid
        localparam int NXT = kmp_next(PAT16, PAT_LEN, k, b != 0);
        assign w_nxt_tab[k][b] = SW'(NXT);
      end else begin : g_unused
        assign w_nxt_tab[k][b] = '0;
      end
    end
  end

  logic [SW-1:0] r_state;
  logic          r_qout;
  logic [SW-1:0] w_next;
  logic          w_inc;

  always_comb begin
    w_next = w_nxt_tab[r_state][bus.din];
    if ((r_state == ST_MATCH) && !bus.overlap_en)
      w_next = w_nxt_tab[0][bus.din];
  end

  assign w_inc = bus.din_vld && !bus.clr && (w_next == ST_MATCH);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= '0;
      r_qout  <= 1'b0;
    end else if (bus.clr) begin
      r_state <= '0;
      r_qout  <= 1'b0;
    end else if (bus.din_vld) begin
      r_state <= w_next;
      r_qout  <= (w_next == ST_MATCH);
    end
  end

  assign bus.qout    = r_qout;
  assign bus.state_o = r_state;

  moore_det_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_inc),
    .i_clr (bus.clr),
`ifdef MOORE_DET_SAT_FLAG_EN
    .o_sat (bus.cnt_sat),
`endif
    .o_cnt (bus.match_cnt)
  );

endmodule

// File: tb/tb_moore_seq_detector.sv
// Scoreboard bench for moore_seq_detector: pattern 1001 on an 8-bit counter
// instance and a 2-bit counter instance for saturation.
module tb_moore_seq_detector;

  logic clk;
  logic rst;

  moore_seq_detector_if #(.PAT_LEN(4), .CNT_W(8)) if_a ();
  moore_seq_detector_if #(.PAT_LEN(4), .CNT_W(2)) if_b ();

  moore_seq_detector #(.PAT_LEN(4), .PATTERN(4'b1001), .CNT_W(8)) u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (if_a)
  );

  moore_seq_detector #(.PAT_LEN(4), .PATTERN(4'b1001), .CNT_W(2)) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (if_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int    dut;
    string nm;
    bit    q;
    int    st;
    int    cnt;
    bit    sat;
  } exp_t;

  exp_t sb_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic check(input string nm, input int act, input int exp_v);
    n_total++;
    if (act == exp_v)
      n_pass++;
    else
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp_v);
  endtask

  // Monitor: outputs are sampled on the falling edge after the accepting edge.
  always @(negedge clk) begin : mon
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      if (e.dut == 0) begin
        check({e.nm, "_q"},   int'(if_a.qout),      int'(e.q));
        check({e.nm, "_st"},  int'(if_a.state_o),   e.st);
        check({e.nm, "_cnt"}, int'(if_a.match_cnt), e.cnt);
`ifdef MOORE_DET_SAT_FLAG_EN
        check({e.nm, "_sat"}, int'(if_a.cnt_sat),   int'(e.sat));
`endif
      end else begin
        check({e.nm, "_q"},   int'(if_b.qout),      int'(e.q));
        check({e.nm, "_st"},  int'(if_b.state_o),   e.st);
        check({e.nm, "_cnt"}, int'(if_b.match_cnt), e.cnt);
`ifdef MOORE_DET_SAT_FLAG_EN
        check({e.nm, "_sat"}, int'(if_b.cnt_sat),   int'(e.sat));
`endif
      end
    end
  end

  // Drive one cycle of stimulus and queue the hand-computed response.
  task automatic step(input int dut, input bit vld, input bit d, input bit c,
                      input bit ov, input int est, input int ecnt, input string nm);
    exp_t e;
    if (dut == 0) begin
      if_a.din_vld = vld; if_a.din = d; if_a.clr = c; if_a.overlap_en = ov;
      if_b.din_vld = 1'b0; if_b.din = 1'b0; if_b.clr = 1'b0; if_b.overlap_en = 1'b0;
    end else begin
      if_b.din_vld = vld; if_b.din = d; if_b.clr = c; if_b.overlap_en = ov;
      if_a.din_vld = 1'b0; if_a.din = 1'b0; if_a.clr = 1'b0; if_a.overlap_en = 1'b0;
    end
    @(posedge clk);
    e.dut = dut;
    e.nm  = nm;
    e.q   = (est == 4);
    e.st  = est;
    e.cnt = ecnt;
    e.sat = (dut == 0) ? (ecnt == 255) : (ecnt == 3);
    sb_q.push_back(e);
    #2;
  endtask

  initial begin
    rst = 1'b0;
    if_a.din_vld = 1'b0; if_a.din = 1'b0; if_a.clr = 1'b0; if_a.overlap_en = 1'b0;
    if_b.din_vld = 1'b0; if_b.din = 1'b0; if_b.clr = 1'b0; if_b.overlap_en = 1'b0;
    #1;
    check("rst_q",     int'(if_a.qout),      0);
    check("rst_st",    int'(if_a.state_o),   0);
    check("rst_cnt",   int'(if_a.match_cnt), 0);
    check("rst_cnt_b", int'(if_b.match_cnt), 0);
    #11;
    rst = 1'b1;

    // overlapping stream 1001001
    step(0, 1, 1, 0, 1, 1, 0, "ov_b1");
    step(0, 1, 0, 0, 1, 2, 0, "ov_b2");
    step(0, 1, 0, 0, 1, 3, 0, "ov_b3");
    step(0, 1, 1, 0, 1, 4, 1, "ov_b4");
    step(0, 1, 0, 0, 1, 2, 1, "ov_b5");
    step(0, 1, 0, 0, 1, 3, 1, "ov_b6");
    step(0, 1, 1, 0, 1, 4, 2, "ov_b7");
    step(0, 0, 0, 0, 1, 4, 2, "ov_hold");
    step(0, 0, 0, 1, 1, 0, 0, "clr1");

    // same stream, restart after match
    step(0, 1, 1, 0, 0, 1, 0, "nov_b1");
    step(0, 1, 0, 0, 0, 2, 0, "nov_b2");
    step(0, 1, 0, 0, 0, 3, 0, "nov_b3");
    step(0, 1, 1, 0, 0, 4, 1, "nov_b4");
    step(0, 1, 0, 0, 0, 0, 1, "nov_b5");
    step(0, 1, 0, 0, 0, 0, 1, "nov_b6");
    step(0, 1, 1, 0, 0, 1, 1, "nov_b7");
    step(0, 0, 0, 1, 0, 0, 0, "clr2");

    // 11001: second 1 falls back to S1
    step(0, 1, 1, 0, 1, 1, 0, "fb_b1");
    step(0, 1, 1, 0, 1, 1, 0, "fb_b2");
    step(0, 1, 0, 0, 1, 2, 0, "fb_b3");
    step(0, 1, 0, 0, 1, 3, 0, "fb_b4");
    step(0, 1, 1, 0, 1, 4, 1, "fb_b5");
    step(0, 0, 0, 1, 1, 0, 0, "clr3");

    // same with invalid cycles interleaved
    step(0, 1, 1, 0, 1, 1, 0, "iv_b1");
    step(0, 0, 0, 0, 1, 1, 0, "iv_gap1");
    step(0, 1, 1, 0, 1, 1, 0, "iv_b2");
    step(0, 0, 1, 0, 1, 1, 0, "iv_gap2");
    step(0, 1, 0, 0, 1, 2, 0, "iv_b3");
    step(0, 1, 0, 0, 1, 3, 0, "iv_b4");
    step(0, 0, 0, 0, 1, 3, 0, "iv_gap3");
    step(0, 1, 1, 0, 1, 4, 1, "iv_b5");
    step(0, 0, 1, 0, 1, 4, 1, "iv_gap4");
    step(0, 0, 0, 1, 1, 0, 0, "clr4");

    // clr on the final pattern bit discards it
    step(0, 1, 1, 0, 1, 1, 0, "cd_b1");
    step(0, 1, 0, 0, 1, 2, 0, "cd_b2");
    step(0, 1, 0, 0, 1, 3, 0, "cd_b3");
    step(0, 1, 1, 1, 1, 0, 0, "cd_b4clr");
    step(0, 1, 1, 0, 1, 1, 0, "cd_after");
    step(0, 0, 0, 1, 1, 0, 0, "clr5");

    // async reset while in S3 with a nonzero count
    step(0, 1, 1, 0, 1, 1, 0, "ar_b1");
    step(0, 1, 0, 0, 1, 2, 0, "ar_b2");
    step(0, 1, 0, 0, 1, 3, 0, "ar_b3");
    step(0, 1, 1, 0, 1, 4, 1, "ar_b4");
    step(0, 1, 0, 0, 1, 2, 1, "ar_b5");
    step(0, 1, 0, 0, 1, 3, 1, "ar_b6");
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("arst_q",   int'(if_a.qout),      0);
    check("arst_st",  int'(if_a.state_o),   0);
    check("arst_cnt", int'(if_a.match_cnt), 0);
    #1;
    rst = 1'b1;
    step(0, 1, 1, 0, 1, 1, 0, "ar_after");

    // 2-bit counter saturation over five overlapping matches
    step(1, 1, 1, 0, 1, 1, 0, "sat_b1");
    step(1, 1, 0, 0, 1, 2, 0, "sat_b2");
    step(1, 1, 0, 0, 1, 3, 0, "sat_b3");
    step(1, 1, 1, 0, 1, 4, 1, "sat_m1");
    for (int m = 2; m <= 5; m++) begin
      step(1, 1, 0, 0, 1, 2, (m - 1 > 3) ? 3 : m - 1, "sat_z1");
      step(1, 1, 0, 0, 1, 3, (m - 1 > 3) ? 3 : m - 1, "sat_z2");
      step(1, 1, 1, 0, 1, 4, (m > 3) ? 3 : m, "sat_m");
    end
    step(1, 0, 0, 1, 1, 0, 0, "sat_clr");

    for (int i = 0; i < 10; i++) begin
      if (sb_q.size() != 0) @(negedge clk);
    end
    #1;
    check("sb_drain", sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
